// File: rtl/mem_seq_pkg.sv
// Shared constants, FSM state type and lane-select helper for the memory beat sequencer.
package mem_seq_pkg;
  localparam int LANE_W  = 16;
  localparam int LANES   = 4;
  localparam int BEAT_W  = 2;
  localparam int ADDR_W  = 16;
  localparam int WORD_W  = LANE_W * LANES;
  localparam int WADDR_W = ADDR_W - BEAT_W;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  function automatic logic [LANE_W-1:0] lane_of(input logic [WORD_W-1:0] w,
                                                input logic [BEAT_W-1:0] b);
    return w[int'(b)*LANE_W +: LANE_W];
  endfunction
endpackage

// File: rtl/lane_assembler.sv
// Four 16-bit lane registers loaded one lane at a time; zero latency (the lane being
// loaded is forwarded onto word_o), no backpressure, contents persist across reset.
module lane_assembler
  import mem_seq_pkg::*;
(
  input  logic              clk,
  input  logic              load_en_i,
  input  logic [BEAT_W-1:0] load_lane_i,
  input  logic [LANE_W-1:0] load_dat_i,
  output logic [WORD_W-1:0] word_o
);
  logic [LANE_W-1:0] lane_q [LANES];

  always_ff @(posedge clk) begin
    if (load_en_i) lane_q[load_lane_i] <= load_dat_i;
  end

  always_comb begin
    word_o = '0;
    for (int k = 0; k < LANES; k++) begin
      word_o[k*LANE_W +: LANE_W] = (load_en_i && load_lane_i == BEAT_W'(k)) ? load_dat_i : lane_q[k];
    end
  end
endmodule

// File: rtl/mem_beat_sequencer.sv
// Serialises a 64-bit controller access into four 16-bit RAM beats; write 4 busy cycles,
// read 5 busy cycles then rd_valid. Requests seen while busy are dropped, not queued.
module mem_beat_sequencer
  import mem_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memWR,
  input  logic              MemREAD,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [WORD_W-1:0] datatoMem,
  output logic [WORD_W-1:0] datafromMem,
  output logic              rd_valid,
  output logic              busy,
  output logic              req_accept,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LANE_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [LANE_W-1:0] ram_rdata
);
  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                pend_q, pend_d;
  logic [WADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]   wdat_q, wdat_d;
  logic                ram_we_q, ram_we_d, ram_re_q, ram_re_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [LANE_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                cap_vld_q;
  logic [BEAT_W-1:0]   cap_lane_q;
  logic [WORD_W-1:0]   rdat_q, rdat_d;
  logic                rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0]   asm_word;
  logic                last_beat;
  logic                unused_addr_hi;

  assign req_accept     = (state_q == IDLE) && (memWR || MemREAD);
  assign last_beat      = &beat_q;
  assign unused_addr_hi = ^memAddr[ADDR_W-1:WADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cap_vld_q   <= 1'b0;
      cap_lane_q  <= '0;
      rdat_q      <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      // RAM returns data one cycle after the strobe, so the capture lane trails the read beat.
      cap_vld_q   <= ram_re_q;
      cap_lane_q  <= ram_addr_q[BEAT_W-1:0];
      rdat_q      <= rdat_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    case (state_q)
      IDLE: begin
        if (req_accept) begin
          state_d = memWR ? WRITE : READ;
          beat_d  = '0;
          pend_d  = memWR && MemREAD;
          addr_d  = memAddr[WADDR_W-1:0];
          wdat_d  = datatoMem;
        end
      end
      WRITE: begin
        beat_d = beat_q + 1'b1;
        if (last_beat) begin
          state_d = pend_q ? READ : IDLE;
          pend_d  = 1'b0;
        end
      end
      READ: begin
        beat_d = beat_q + 1'b1;
        if (last_beat) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM-side outputs are registered, so they are decoded from the next state.
  always_comb begin
    ram_we_d    = (state_d == WRITE);
    ram_re_d    = (state_d == READ);
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (ram_we_d || ram_re_d) ram_addr_d = {addr_d, beat_d};
    if (ram_we_d) ram_wdata_d = lane_of(wdat_d, beat_d);
    rd_valid_d  = cap_vld_q && (&cap_lane_q);
    rdat_d      = rd_valid_d ? asm_word : rdat_q;
  end

  lane_assembler u_lane_asm (
    .clk         (clk),
    .load_en_i   (cap_vld_q),
    .load_lane_i (cap_lane_q),
    .load_dat_i  (ram_rdata),
    .word_o      (asm_word)
  );

  assign busy        = (state_q != IDLE);
  assign ram_we      = ram_we_q;
  assign ram_re      = ram_re_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign datafromMem = rdat_q;
  assign rd_valid    = rd_valid_q;
endmodule

// File: tb/tb_mem_beat_sequencer.sv
// Randomised bench for mem_beat_sequencer against a word-level memory model and a beat RAM.
module tb_mem_beat_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        memWR, MemREAD;
  logic [15:0] memAddr;
  logic [63:0] datatoMem;
  logic [63:0] datafromMem;
  logic        rd_valid, busy, req_accept;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, ram_re;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] ram_mem [65536];
  logic [63:0] mdl [16384];
  logic [63:0] exp_dout;

  always #5 clk = ~clk;

  mem_beat_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .memWR       (memWR),
    .MemREAD     (MemREAD),
    .memAddr     (memAddr),
    .datatoMem   (datatoMem),
    .datafromMem (datafromMem),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .req_accept  (req_accept),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_re      (ram_re),
    .ram_rdata   (ram_rdata)
  );

  // Physical RAM: read data valid exactly one cycle after ram_re, garbage otherwise.
  always @(posedge clk) begin
    ram_rdata <= ram_re ? ram_mem[ram_addr] : 16'($urandom);
    if (ram_we) ram_mem[ram_addr] = ram_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge while idle; leaves off at the negedge of the first idle cycle.
  task automatic run_txn(input bit wr, input bit rd, input logic [15:0] a,
                         input logic [63:0] d, input bit noise);
    int n, r0, b;
    bit e_we, e_re, e_busy, e_vld;
    logic [63:0] rword;
    logic [15:0] e_addr;
    n  = (wr && rd) ? 10 : (rd ? 6 : 5);
    r0 = wr ? 5 : 1;
    if (wr) mdl[a[13:0]] = d;
    rword = mdl[a[13:0]];
    memWR = wr; MemREAD = rd; memAddr = a; datatoMem = d;
    #1;
    chk_eq("accept", 64'(req_accept), 64'd1);
    chk_eq("idle_busy", 64'(busy), 64'd0);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      memWR = 1'b0; MemREAD = 1'b0;
      memAddr = 16'($urandom); datatoMem = {$urandom, $urandom};
      if (noise && c == 2) begin
        memWR   = 1'($urandom_range(0, 1));
        MemREAD = !memWR;
      end
      @(negedge clk);
      e_we   = wr && c <= 4;
      e_re   = rd && c >= r0 && c <= r0 + 3;
      e_busy = c < n;
      e_vld  = rd && c == n;
      b      = e_we ? c - 1 : c - r0;
      e_addr = {a[13:0], 2'(b)};
      if (e_vld) exp_dout = rword;
      chk_eq($sformatf("c%0d_we", c), 64'(ram_we), 64'(e_we));
      chk_eq($sformatf("c%0d_re", c), 64'(ram_re), 64'(e_re));
      chk_eq($sformatf("c%0d_busy", c), 64'(busy), 64'(e_busy));
      chk_eq($sformatf("c%0d_acc", c), 64'(req_accept), 64'(!e_busy && (memWR || MemREAD)));
      chk_eq($sformatf("c%0d_rdv", c), 64'(rd_valid), 64'(e_vld));
      chk_eq($sformatf("c%0d_dout", c), datafromMem, exp_dout);
      if (e_we || e_re) chk_eq($sformatf("c%0d_addr", c), 64'(ram_addr), 64'(e_addr));
      if (e_we) chk_eq($sformatf("c%0d_wdat", c), 64'(ram_wdata), 64'(d[16*b +: 16]));
    end
  endtask

  initial begin
    logic [63:0] d0;
    logic [15:0] ra;
    int op;
    for (int i = 0; i < 65536; i++) ram_mem[i] = 16'h0;
    for (int i = 0; i < 16384; i++) mdl[i] = 64'h0;
    exp_dout = 64'h0;
    rst_n = 1'b0; memWR = 1'b0; MemREAD = 1'b0; memAddr = 16'h0; datatoMem = 64'h0;
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_we", 64'(ram_we), 64'd0);
    chk_eq("rst_re", 64'(ram_re), 64'd0);
    chk_eq("rst_addr", 64'(ram_addr), 64'd0);
    chk_eq("rst_wdat", 64'(ram_wdata), 64'd0);
    chk_eq("rst_dout", datafromMem, 64'd0);
    chk_eq("rst_rdv", 64'(rd_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during beat 2 of a write: beats 0 and 1 stay in RAM.
    d0 = 64'h0123_4567_89AB_CDEF;
    memWR = 1'b1; memAddr = 16'h0010; datatoMem = d0;
    #1 chk_eq("mid_accept", 64'(req_accept), 64'd1);
    @(posedge clk); #1 memWR = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_eq("mid_we_pre", 64'(ram_we), 64'd1);
    chk_eq("mid_addr_pre", 64'(ram_addr), 64'h0042);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_we", 64'(ram_we), 64'd0);
    chk_eq("mid_re", 64'(ram_re), 64'd0);
    chk_eq("mid_busy", 64'(busy), 64'd0);
    chk_eq("mid_dout", datafromMem, 64'd0);
    chk_eq("mid_addr", 64'(ram_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl[14'h0010] = {32'h0, d0[31:0]};
    exp_dout = 64'h0;
    @(negedge clk);

    run_txn(1'b0, 1'b1, 16'h0010, 64'h0, 1'b0);
    run_txn(1'b1, 1'b0, 16'h0003, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0);
    run_txn(1'b0, 1'b1, 16'h0003, 64'h0, 1'b0);
    run_txn(1'b1, 1'b1, 16'h0005, 64'h1111_2222_3333_4444, 1'b0);
    run_txn(1'b1, 1'b0, 16'h0007, 64'h5555_6666_7777_8888, 1'b1);
    run_txn(1'b0, 1'b1, 16'h0007, 64'h0, 1'b1);
    run_txn(1'b1, 1'b0, 16'hC001, 64'h9999_AAAA_BBBB_CCCC, 1'b0);
    run_txn(1'b0, 1'b1, 16'h0001, 64'h0, 1'b0);
    run_txn(1'b0, 1'b1, 16'h4001, 64'h0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op = $urandom_range(0, 2);
      ra = 16'($urandom_range(0, 7)) | (16'($urandom_range(0, 3)) << 14);
      run_txn(op != 1, op != 0, ra, {$urandom, $urandom}, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/mem_beat_sequencer.md
Name: mem_beat_sequencer

Overview:
- Sits directly downstream of the four-core memory controller, between it and the physical data RAM.
- Takes the controller's single 64-bit request (memWR/MemREAD, memAddr, datatoMem) and serialises it into four 16-bit RAM beats.
- For reads, reassembles four returned beats into datafromMem.
- Provides busy/accept handshaking so the controller and cores stall while a multi-beat access is in flight.

Parameters:
- LANE_W, 16, width of one RAM beat and one core lane.
- LANES, 4, beats per controller word; fixed at 4, sized for the 4-core packing.
- ADDR_W, 16, width of memAddr and ram_addr.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- memWR  in  1  write request from memory controller.
- MemREAD  in  1  read request from memory controller.
- memAddr  in  16  controller word address.
- datatoMem  in  64  write word; lane k = bits [16k+15:16k].
- datafromMem  out  64  assembled read word, held until the next read completes.
- rd_valid  out  1  one-cycle pulse when datafromMem is updated.
- busy  out  1  high whenever state != IDLE.
- req_accept  out  1  combinational: state==IDLE & (memWR|MemREAD).
- ram_addr  out  16  beat address = {memAddr[13:0], beat[1:0]}.
- ram_wdata  out  16  write beat.
- ram_we  out  1  RAM write strobe, registered.
- ram_re  out  1  RAM read strobe, registered.
- ram_rdata  in  16  RAM read data, valid exactly 1 cycle after its ram_re cycle.

Behaviour:
- Reset (rst_n low, any time, including mid-burst):
  - state=IDLE, beat counter=0.
  - ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0.
  - datafromMem=0, rd_valid=0, pending-read flag=0.
  - A partially written word stays partially written; there is no rollback.
- States: IDLE, WRITE, READ, DRAIN.
- Request capture:
  - In IDLE, at a rising edge with req_accept=1, register memAddr and datatoMem.
  - Upstream must drop its request the cycle after req_accept.
  - Requests while busy are ignored and not queued.
- Write, accepted at edge T:
  - Cycles T+1..T+4: ram_we=1, beat b=0..3.
  - ram_addr = {addr[13:0], b}, ram_wdata = lane b.
  - Return to IDLE; busy low from T+5.
- Read, accepted at edge T:
  - Cycles T+1..T+4 (READ): ram_re=1, beats 0..3.
  - ram_rdata for beat b is captured at the end of cycle T+2+b; beat 3 is captured during DRAIN (T+5).
  - Cycle T+6: datafromMem holds the assembled word, rd_valid=1 for that cycle only, busy=0.
  - A new request may be accepted in T+6.
- Simultaneous memWR & MemREAD: run the full write, then set pending read and go directly WRITE→READ at the same address without passing through IDLE.
  - Read data equals the just-written word.
  - busy stays high continuously; total 10 cycles.
- memAddr[15:14] are discarded; the address wraps modulo 2^14 words.
- datafromMem changes only on rd_valid; writes never disturb it.
- ram_we and ram_re are never high together.

Decomposition:
- Package mem_seq_pkg holds:
  - state enum {IDLE, WRITE, READ, DRAIN};
  - constants LANE_W=16, LANES=4, BEAT_W=2.
- One sub-module, lane_assembler:
  - 4×16 shift/lane register with load-lane-b enable and a 64-bit output;
  - holds contents on reset release until written.

Test Plan:
- Reset mid-write: assert rst_n=0 during beat 2 of a write to 0x0010 → ram_we=0 immediately, busy=0, datafromMem=0; the next request is accepted normally.
- Single write: memWR, memAddr=0x0003, datatoMem=0xDDDD_CCCC_BBBB_AAAA → ram_addr 0x000C..0x000F with wdata AAAA, BBBB, CCCC, DDDD on T+1..T+4; busy low at T+5.
- Read back: MemREAD at 0x0003 after the above → ram_re at T+1..T+4; rd_valid pulse at T+6; datafromMem=0xDDDD_CCCC_BBBB_AAAA; busy=0 at T+6.
- Simultaneous request: memWR=MemREAD=1, addr 0x0005, data 0x1111_2222_3333_4444 → 4 write beats then 4 read beats; rd_valid at T+10 with the same data; busy continuous.
- Request while busy: pulse MemREAD during a write → no extra ram_re; datafromMem unchanged.
- Address wrap: memAddr=0xC001 → ram_addr 0x0004..0x0007, identical to memAddr=0x0001.
